// File: rtl/ether_frame_tx_pkg.sv
// Shared definitions for the Ethernet frame transmitter: state encoding,
// fixed frame bytes, CRC-32 constants and header field sizes.
package ether_pkg;

  typedef enum logic [3:0] {
    IDLE, PRE, SFD, DA, SA, LEN, DATA, PAD, FCS, IFG
  } state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

  localparam logic [15:0] PRE_BYTES = 16'd7;
  localparam logic [15:0] DA_BYTES  = 16'd6;
  localparam logic [15:0] SA_BYTES  = 16'd6;
  localparam logic [15:0] LEN_BYTES = 16'd2;
  localparam logic [15:0] FCS_BYTES = 16'd4;

  // Bit-reverse a 32-bit word (turns the normal polynomial into its LSB-first form).
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/ether_frame_tx_crc32_d8.sv
// Byte-parallel Ethernet CRC-32 (LSB-first). Holds the raw running
// remainder; the caller applies the final complement.
module crc32_d8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [31:0] crc
);
  import ether_pkg::*;

  localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h000000, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ POLY_REFL) : (r >> 1);
    return r;
  endfunction

  // Next remainder: restart on init, fold in one byte on en, else hold.
  always_comb begin
    crc_d = crc_q;
    if (init)    crc_d = CRC_INIT;
    else if (en) crc_d = crc_byte(crc_q, d);
  end

  // Remainder register.
  always_ff @(posedge clk) begin
    if (!rst_n) crc_q <= CRC_INIT;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/ether_frame_tx.sv
// Ethernet frame transmitter: preamble, SFD, DA, SA, length, streamed
// payload, pad, FCS and inter-frame gap over a valid/ready byte stream.
module ether_frame_tx #(
  parameter int         MAX_PAYLOAD = 1500,
  parameter int         MIN_PAYLOAD = 46,
  parameter int         IFG_BYTES   = 12,
  parameter logic [7:0] PAD_BYTE    = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [47:0] da,
  input  logic [47:0] sa,
  input  logic [15:0] len,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_sof,
  output logic        tx_eof,
  output logic        busy,
  output logic        err
);
  import ether_pkg::*;

  localparam logic [15:0] MIN16    = 16'(MIN_PAYLOAD);
  localparam logic [15:0] MAX16    = 16'(MAX_PAYLOAD);
  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);

  state_e      state_q, state_d, nxt;
  logic [15:0] cnt_q, cnt_d;
  logic [47:0] da_q, da_d, sa_q, sa_d;
  logic [15:0] len_q, len_d;
  logic        err_q, err_d;
  logic        last, xfer, crc_init, crc_en, need_pad, ifg_done, can_start;
  logic [15:0] pad_last;
  logic [31:0] crc, fcs;

  function automatic logic [7:0] msb_byte6(input logic [47:0] v, input logic [2:0] i);
    case (i)
      3'd0:    return v[47:40];
      3'd1:    return v[39:32];
      3'd2:    return v[31:24];
      3'd3:    return v[23:16];
      3'd4:    return v[15:8];
      default: return v[7:0];
    endcase
  endfunction

  function automatic logic [7:0] lsb_byte4(input logic [31:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return v[7:0];
      2'd1:    return v[15:8];
      2'd2:    return v[23:16];
      default: return v[31:24];
    endcase
  endfunction

  assign need_pad = (len_q < MIN16);
  assign pad_last = MIN16 - len_q - 16'd1;
  assign fcs      = ~crc;
  // The final gap cycle already counts as idle so a back-to-back start
  // there keeps exactly IFG_BYTES dead cycles between frames.
  assign ifg_done  = (state_q == IFG) && (cnt_q == IFG_LAST);
  assign can_start = (state_q == IDLE) || ifg_done;
  assign busy      = !can_start;
  assign err       = err_q;

  // Byte mux, handshake, frame sequencing and start acceptance.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    da_d     = da_q;
    sa_d     = sa_q;
    len_d    = len_q;
    err_d    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_sof   = 1'b0;
    tx_eof   = 1'b0;
    pl_ready = 1'b0;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    last     = 1'b0;
    nxt      = IDLE;
    case (state_q)
      PRE: begin
        tx_valid = 1'b1;
        tx_data  = PREAMBLE_BYTE;
        tx_sof   = (cnt_q == 16'd0);
        last     = (cnt_q == PRE_BYTES - 16'd1);
        nxt      = SFD;
      end
      SFD: begin
        tx_valid = 1'b1;
        tx_data  = SFD_BYTE;
        last     = 1'b1;
        nxt      = DA;
      end
      DA: begin
        tx_valid = 1'b1;
        tx_data  = msb_byte6(da_q, cnt_q[2:0]);
        last     = (cnt_q == DA_BYTES - 16'd1);
        nxt      = SA;
      end
      SA: begin
        tx_valid = 1'b1;
        tx_data  = msb_byte6(sa_q, cnt_q[2:0]);
        last     = (cnt_q == SA_BYTES - 16'd1);
        nxt      = LEN;
      end
      LEN: begin
        tx_valid = 1'b1;
        tx_data  = (cnt_q == 16'd0) ? len_q[15:8] : len_q[7:0];
        last     = (cnt_q == LEN_BYTES - 16'd1);
        nxt      = (len_q != 16'd0) ? DATA : (need_pad ? PAD : FCS);
      end
      DATA: begin
        tx_valid = pl_valid;
        tx_data  = pl_data;
        pl_ready = tx_ready;
        last     = (cnt_q == len_q - 16'd1);
        nxt      = need_pad ? PAD : FCS;
      end
      PAD: begin
        tx_valid = 1'b1;
        tx_data  = PAD_BYTE;
        last     = (cnt_q == pad_last);
        nxt      = FCS;
      end
      FCS: begin
        tx_valid = 1'b1;
        tx_data  = lsb_byte4(fcs, cnt_q[1:0]);
        tx_eof   = (cnt_q == FCS_BYTES - 16'd1);
        last     = tx_eof;
        nxt      = IFG;
      end
      default: ;
    endcase

    xfer = tx_valid && tx_ready;
    if (xfer) begin
      crc_en = (state_q inside {DA, SA, LEN, DATA, PAD});
      if (last) begin
        state_d = nxt;
        cnt_d   = 16'd0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    if (state_q == IFG) begin
      if (ifg_done) begin
        state_d = IDLE;
        cnt_d   = 16'd0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    if (can_start && start) begin
      if (len > MAX16) begin
        err_d = 1'b1;
      end else begin
        state_d  = PRE;
        cnt_d    = 16'd0;
        da_d     = da;
        sa_d     = sa;
        len_d    = len;
        crc_init = 1'b1;
      end
    end
  end

  // Control state: FSM, byte counter, error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Header fields latched at start; only read while a frame is active.
  always_ff @(posedge clk) begin
    da_q  <= da_d;
    sa_q  <= sa_d;
    len_q <= len_d;
  end

  crc32_d8 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (crc_init),
    .en    (crc_en),
    .d     (tx_data),
    .crc   (crc)
  );

endmodule

// File: tb/tb_ether_frame_tx.sv
// Directed bench for ether_frame_tx: table of frame vectors plus
// hand-written sequences for reject, mid-frame reset and back-to-back starts.
module tb_ether_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [47:0] da, sa;
  logic [15:0] len;
  logic [7:0]  pl_data;
  logic        pl_valid, pl_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, tx_sof, tx_eof, busy, err;

  always #5 clk = ~clk;

  ether_frame_tx dut (
    .clk(clk), .rst_n(rst_n), .start(start), .da(da), .sa(sa), .len(len),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_sof(tx_sof), .tx_eof(tx_eof), .busy(busy), .err(err)
  );

  typedef struct {
    logic [15:0] len;
    logic [47:0] da;
    logic [47:0] sa;
    int          rm;         // 1: tx_ready toggles every cycle
    int          pm;         // 1: pl_valid low every third cycle
    int          exp_total;
    int          exp_pad;
  } vec_t;

  vec_t vecs[5];

  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [7:0] cap[$];
  logic [7:0] exp_q[$];
  int sof_cyc[$], eof_cyc[$], sof_idx[$], eof_idx[$];
  int pl_cnt, pl_idx, err_cnt, busy_seen, tv_seen, first_tv_cyc, rm, pm;
  logic pl_hs, busy_s, tv_s;

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_capture();
    cap.delete(); sof_cyc.delete(); eof_cyc.delete(); sof_idx.delete(); eof_idx.delete();
    pl_cnt = 0; err_cnt = 0; busy_seen = 0; tv_seen = 0; first_tv_cyc = -1;
  endtask

  task automatic sample();
    @(negedge clk);
    cyc++;
    pl_hs  = 1'b0;
    busy_s = busy;
    tv_s   = tx_valid;
    if (rst_n) begin
      if (tx_valid && first_tv_cyc < 0) first_tv_cyc = cyc;
      if (tx_valid && tx_ready) begin
        cap.push_back(tx_data);
        if (tx_sof) begin sof_cyc.push_back(cyc); sof_idx.push_back(cap.size() - 1); end
        if (tx_eof) begin eof_cyc.push_back(cyc); eof_idx.push_back(cap.size() - 1); end
      end
      if (pl_valid && pl_ready) begin pl_hs = 1'b1; pl_cnt++; end
      if (err) err_cnt++;
      if (busy) busy_seen++;
      if (tx_valid) tv_seen++;
    end
  endtask

  task automatic tick();
    sample();
    @(posedge clk); #1;
    if (pl_hs) pl_idx++;
    pl_data  = pat(pl_idx);
    tx_ready = (rm == 1) ? ~tx_ready : 1'b1;
    pl_valid = (pm == 1) ? ((cyc % 3) != 0) : 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b1; len = 16'd46; rm = 0; pm = 0;
    tick(); tick();
    check("reset_outputs", {tx_valid, tx_sof, tx_eof, pl_ready, busy, err, tx_data}, 64'd0);
    start = 1'b0; rst_n = 1'b1;
  endtask

  // Bit-serial MSB-first LFSR fed LSB-first data; bit-reversed and complemented at the end.
  function automatic logic [31:0] ref_fcs(input int from, input int to);
    logic [31:0] c, r;
    logic fb;
    c = 32'hFFFFFFFF;
    for (int i = from; i < to; i++)
      for (int b = 0; b < 8; b++) begin
        fb = c[31] ^ exp_q[i][b];
        c  = {c[30:0], 1'b0};
        if (fb) c = c ^ 32'h04C11DB7;
      end
    for (int b = 0; b < 32; b++) r[b] = c[31-b];
    return ~r;
  endfunction

  function automatic void build_expected(input vec_t v);
    logic [31:0] f;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) exp_q.push_back(v.da[8*i +: 8]);
    for (int i = 5; i >= 0; i--) exp_q.push_back(v.sa[8*i +: 8]);
    exp_q.push_back(v.len[15:8]);
    exp_q.push_back(v.len[7:0]);
    for (int i = 0; i < int'(v.len); i++) exp_q.push_back(pat(i));
    for (int i = int'(v.len); i < 46; i++) exp_q.push_back(8'h00);
    f = ref_fcs(8, exp_q.size());
    exp_q.push_back(f[7:0]);
    exp_q.push_back(f[15:8]);
    exp_q.push_back(f[23:16]);
    exp_q.push_back(f[31:24]);
  endfunction

  task automatic run_frame(input vec_t v, input string tag);
    int start_cyc, n, busy_low, ifg_tv, mism, pads;
    logic [31:0] fcs_got, fcs_exp;
    clear_capture();
    rm = v.rm; pm = v.pm; pl_idx = 0; pl_data = pat(0);
    da = v.da; sa = v.sa; len = v.len; start = 1'b1;
    start_cyc = cyc + 1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 1000 && eof_cyc.size() == 0; k++) tick();
    busy_low = -1; ifg_tv = 0;
    for (int k = 0; k < 40 && busy_low < 0; k++) begin
      tick();
      if (tv_s) ifg_tv++;
      if (!busy_s) busy_low = cyc;
    end
    build_expected(v);
    n = cap.size();
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= n || cap[i] !== exp_q[i]) mism++;
    pads = 0;
    for (int i = 22 + int'(v.len); i < n - 4; i++) if (cap[i] == 8'h00) pads++;
    fcs_got = (n >= 4) ? {cap[n-1], cap[n-2], cap[n-3], cap[n-4]} : 32'h0;
    fcs_exp = {exp_q[v.exp_total-1], exp_q[v.exp_total-2], exp_q[v.exp_total-3], exp_q[v.exp_total-4]};
    check($sformatf("%s_first_valid_latency", tag), first_tv_cyc - start_cyc, 1);
    check($sformatf("%s_byte_count", tag), n, v.exp_total);
    check($sformatf("%s_byte_mismatches", tag), mism, 0);
    check($sformatf("%s_sof_index", tag), (sof_idx.size() > 0) ? sof_idx[0] : -1, 0);
    check($sformatf("%s_eof_index", tag), (eof_idx.size() > 0) ? eof_idx[0] : -1, v.exp_total - 1);
    check($sformatf("%s_payload_consumed", tag), pl_cnt, v.len);
    check($sformatf("%s_pad_bytes", tag), pads, v.exp_pad);
    check($sformatf("%s_fcs", tag), fcs_got, fcs_exp);
    check($sformatf("%s_busy_low_after_eof", tag),
          (eof_cyc.size() > 0 && busy_low >= 0) ? busy_low - eof_cyc[0] : -1, 12);
    check($sformatf("%s_valid_in_gap", tag), ifg_tv, 0);
    check($sformatf("%s_err_pulses", tag), err_cnt, 0);
  endtask

  initial begin
    int mism;
    rst_n = 1'b0; start = 1'b0; da = '0; sa = '0; len = '0;
    pl_data = pat(0); pl_valid = 1'b1; tx_ready = 1'b1; rm = 0; pm = 0; pl_idx = 0;
    clear_capture();

    vecs[0] = '{len: 16'd46,  da: 48'h0011_2233_4455, sa: 48'hA0B1_C2D3_E4F5, rm: 0, pm: 0, exp_total: 72,  exp_pad: 0};
    vecs[1] = '{len: 16'd10,  da: 48'hFFFF_FFFF_FFFF, sa: 48'h0200_0000_0001, rm: 0, pm: 1, exp_total: 72,  exp_pad: 36};
    vecs[2] = '{len: 16'd100, da: 48'h1234_5678_9ABC, sa: 48'hDEAD_BEEF_0042, rm: 1, pm: 0, exp_total: 126, exp_pad: 0};
    vecs[3] = '{len: 16'd0,   da: 48'h0102_0304_0506, sa: 48'h0A0B_0C0D_0E0F, rm: 0, pm: 0, exp_total: 72,  exp_pad: 46};
    vecs[4] = '{len: 16'd60,  da: 48'h8000_0000_0001, sa: 48'h7FFF_FFFF_FFFE, rm: 1, pm: 1, exp_total: 86,  exp_pad: 0};

    do_reset();
    for (int r = 0; r < 5; r++) run_frame(vecs[r], $sformatf("vec%0d", r));

    // Oversized length is rejected.
    do_reset();
    clear_capture();
    len = 16'd1501; da = vecs[0].da; sa = vecs[0].sa; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    check("reject_err_pulses", err_cnt, 1);
    check("reject_busy_cycles", busy_seen, 0);
    check("reject_valid_cycles", tv_seen, 0);

    // Reset while byte 30 is on the bus aborts the frame.
    do_reset();
    clear_capture();
    pl_idx = 0; pl_data = pat(0);
    da = vecs[0].da; sa = vecs[0].sa; len = 16'd46; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 500 && cap.size() < 30; k++) tick();
    check("abort_bytes_before_reset", cap.size(), 30);
    rst_n = 1'b0;
    tick();
    check("abort_valid_busy_after_reset", {tx_valid, busy}, 0);
    check("abort_no_fcs", eof_idx.size(), 0);
    rst_n = 1'b1;
    run_frame(vecs[0], "after_abort");

    // Start held high: back-to-back frames separated by the gap.
    do_reset();
    clear_capture();
    pl_idx = 0; pl_data = pat(0);
    da = vecs[0].da; sa = vecs[0].sa; len = 16'd46; start = 1'b1;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (eof_cyc.size() > sof_cyc.size() - 1 && pl_idx >= 46) pl_idx = 0;
    end
    start = 1'b0;
    build_expected(vecs[0]);
    check("b2b_sof_count", sof_cyc.size(), 3);
    check("b2b_eof_count", eof_cyc.size(), 2);
    check("b2b_first_frame_span", (sof_cyc.size() > 0 && eof_cyc.size() > 0) ? eof_cyc[0] - sof_cyc[0] : -1, 71);
    check("b2b_gap_1", (sof_cyc.size() > 1 && eof_cyc.size() > 0) ? sof_cyc[1] - eof_cyc[0] : -1, 13);
    check("b2b_gap_2", (sof_cyc.size() > 2 && eof_cyc.size() > 1) ? sof_cyc[2] - eof_cyc[1] : -1, 13);
    mism = 0;
    for (int i = 0; i < 144; i++)
      if (i >= cap.size() || cap[i] !== exp_q[i % 72]) mism++;
    check("b2b_two_frames_data", mism, 0);
    check("b2b_err_pulses", err_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ether_frame_tx.md
ETHER_FRAME_TX -- requirements
Module: ether_frame_tx

Interface
REQ-001 Parameter MAX_PAYLOAD, 1500: largest accepted payload length in bytes.
REQ-002 Parameter MIN_PAYLOAD, 46: payload is padded up to this length.
REQ-003 Parameter IFG_BYTES, 12: idle byte-times after each frame.
REQ-004 Parameter PAD_BYTE, 8'h00: fill value for pad bytes.
REQ-005 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 start  input  1  frame request, sampled only while busy=0.
REQ-008 da, sa  input  48 each  destination/source address, latched on start.
REQ-009 len  input  16  payload length/type field, latched on start.
REQ-010 pl_data  input  8  payload byte; pl_valid input 1; pl_ready output 1.
REQ-011 tx_data  output  8  frame byte; tx_valid output 1; tx_ready input 1.
REQ-012 tx_sof, tx_eof  output  1 each  mark the first preamble byte and the last FCS byte.
REQ-013 busy  output  1  high from accepted start through end of IFG.
REQ-014 err  output  1  one-cycle pulse on a rejected start.

Function
REQ-015 FSM states SHALL be IDLE, PRE, SFD, DA, SA, LEN, DATA, PAD, FCS, IFG, in that order.
REQ-016 In IDLE, start=1 with len<=MAX_PAYLOAD SHALL latch da/sa/len, set busy, and enter PRE; the first tx_valid occurs on the next cycle.
REQ-017 start with len>MAX_PAYLOAD SHALL pulse err for one cycle and leave the FSM in IDLE.
REQ-018 PRE SHALL emit 7 bytes of 8'h55; SFD SHALL emit 1 byte of 8'hD5.
REQ-019 DA, SA and LEN SHALL each emit the most-significant byte first (6, 6 and 2 bytes).
REQ-020 DATA SHALL consume exactly len bytes via pl_valid/pl_ready; a byte transfers when both are high.
REQ-021 pl_ready SHALL equal (state==DATA && tx_ready).
REQ-022 tx_valid SHALL be low in DATA while pl_valid is low (bubble).
REQ-023 PAD SHALL emit max(0, MIN_PAYLOAD-len) bytes of PAD_BYTE; len=0 is legal and yields 46 pad bytes.
REQ-024 FCS SHALL be CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final complement) over DA..PAD.
REQ-025 FCS SHALL be emitted in 4 bytes, least-significant byte first.
REQ-026 Every tx byte transfers only when tx_valid && tx_ready; while tx_ready=0, tx_data, tx_valid, state, counters and CRC SHALL hold.
REQ-027 IFG SHALL hold tx_valid=0 for IFG_BYTES cycles, counted regardless of tx_ready, then enter IDLE with busy=0.
REQ-028 A start asserted while busy=1 SHALL be ignored; there is no queueing.
REQ-029 The byte counter SHALL be 16 bits and SHALL not wrap within a legal frame.

Reset
REQ-030 rst_n=0 at a clock edge SHALL force IDLE, with tx_valid, tx_sof, tx_eof, pl_ready, busy and err all 0, tx_data 8'h00, and counters 0.
REQ-031 Reset mid-frame SHALL abort the frame without emitting an FCS; the block accepts start on the first cycle after rst_n returns high.

Structure
REQ-032 Package ether_pkg SHALL hold the state enum, PREAMBLE_BYTE, SFD_BYTE, CRC_POLY, CRC_INIT and the header byte counts.
REQ-033 CRC logic SHALL be sub-module crc32_d8: byte-parallel next-state function with inputs clk, rst_n, init, en, d[7:0] and output crc[31:0].

Verification
REQ-034 len=46, pl_valid always 1, tx_ready always 1:
- 72 tx bytes (8+14+46+4), sof on byte 0, eof on byte 71.
- FCS matches the bench reference model; then 12 idle cycles, then busy=0.

REQ-035 len=10: 10 payload bytes consumed, followed by 36 bytes of 8'h00, 72 bytes total; FCS covers the pad.

REQ-036 len=100, tx_ready toggling every cycle: 126 bytes delivered unchanged and in order; no byte duplicated or dropped.

REQ-037 len=1501: err pulses for 1 cycle; busy stays 0; no tx_valid.

REQ-038 rst_n low at byte 30 of a frame: next cycle tx_valid=0 and busy=0; a new start with len=46 then produces a correct 72-byte frame.

REQ-039 start held high for 200 cycles with len=46: exactly one frame per start-to-idle interval; the second frame's sof occurs exactly 13 cycles after the first frame's eof.
